// File: rtl/serial_uart_pkg.sv
// Shared types and frame constants for the serial UART endpoint.
package serial_uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; power-of-two depth so pointers wrap naturally.
module serial_tx_fifo
    import serial_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 do_push;
    logic                 do_pop;

    // A write while full is dropped even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_endpoint.sv
// 8N1 UART endpoint with TX FIFO and single-byte RX holding register.
// Optional SERIAL_LOOPBACK_EN feeds uart_tx_out back into the RX synchronizer.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a FIFO byte
// TX_START | start bit (0)
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1), then next byte back-to-back or idle
// RX_IDLE  | waiting for falling edge
// RX_START | half-bit wait, glitch reject
// RX_DATA  | sample 8 bits mid-bit
// RX_STOP  | sample stop bit, framing check
module serial_uart_endpoint
    import serial_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    output logic       cpu_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    serial_tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (cpu_wren_in),
        .push_data(cpu_data_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cpu_ready_out = !fifo_full;

    tx_state_t            tx_state, tx_next;
    logic [15:0]          tx_tmr, tx_tmr_next;
    logic [2:0]           tx_idx, tx_idx_next;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
    logic                 tx_line;

    always_comb begin
        tx_next       = tx_state;
        tx_tmr_next   = tx_tmr;
        tx_idx_next   = tx_idx;
        tx_shift_next = tx_shift;
        tx_line       = 1'b1;
        fifo_pop      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_shift_next = fifo_head;
                    tx_tmr_next   = BIT_LAST;
                    tx_next       = TX_START;
                end
            end
            TX_START: begin
                tx_line = START_BIT;
                if (tx_tmr == '0) begin
                    tx_tmr_next = BIT_LAST;
                    tx_idx_next = '0;
                    tx_next     = TX_DATA;
                end else begin
                    tx_tmr_next = tx_tmr - 16'd1;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tmr == '0) begin
                    tx_tmr_next   = BIT_LAST;
                    tx_shift_next = tx_shift >> 1;
                    if (tx_idx == IDX_LAST) begin
                        tx_next = TX_STOP;
                    end else begin
                        tx_idx_next = tx_idx + 3'd1;
                    end
                end else begin
                    tx_tmr_next = tx_tmr - 16'd1;
                end
            end
            TX_STOP: begin
                tx_line = STOP_BIT;
                if (tx_tmr == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_shift_next = fifo_head;
                        tx_tmr_next   = BIT_LAST;
                        tx_next       = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end else begin
                    tx_tmr_next = tx_tmr - 16'd1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx_tmr      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            tx_state    <= tx_next;
            tx_tmr      <= tx_tmr_next;
            tx_idx      <= tx_idx_next;
            tx_shift    <= tx_shift_next;
            uart_tx_out <= tx_line;
        end
    end

    logic rx_src;
`ifdef SERIAL_LOOPBACK_EN
    assign rx_src = uart_tx_out;
`else
    assign rx_src = uart_rx_in;
`endif

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t            rx_state, rx_next;
    logic [15:0]          rx_tmr, rx_tmr_next;
    logic [2:0]           rx_idx, rx_idx_next;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_next;
    logic                 rx_good, rx_good_next;

    always_comb begin
        rx_next       = rx_state;
        rx_tmr_next   = rx_tmr;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_good_next  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_tmr_next = HALF_LAST;
                    rx_next     = RX_START;
                end
            end
            RX_START: begin
                if (rx_tmr == '0) begin
                    if (rx_sync) begin
                        rx_next = RX_IDLE;
                    end else begin
                        rx_tmr_next = BIT_LAST;
                        rx_idx_next = '0;
                        rx_next     = RX_DATA;
                    end
                end else begin
                    rx_tmr_next = rx_tmr - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_tmr == '0) begin
                    rx_tmr_next   = BIT_LAST;
                    rx_shift_next = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_LAST) begin
                        rx_next = RX_STOP;
                    end else begin
                        rx_idx_next = rx_idx + 3'd1;
                    end
                end else begin
                    rx_tmr_next = rx_tmr - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_tmr == '0) begin
                    rx_good_next = (rx_sync == STOP_BIT);
                    rx_next      = RX_IDLE;
                end else begin
                    rx_tmr_next = rx_tmr - 16'd1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_tmr   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_good  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_tmr   <= rx_tmr_next;
            rx_idx   <= rx_idx_next;
            rx_shift <= rx_shift_next;
            rx_good  <= rx_good_next;
        end
    end

    // rx_shift is stable while idle, so it still holds the byte when rx_good is seen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cpu_data_out   <= '0;
            cpu_valid_out  <= 1'b0;
            rx_overrun_out <= 1'b0;
        end else if (rx_good) begin
            if (!cpu_valid_out || cpu_rden_in) begin
                cpu_data_out  <= rx_shift;
                cpu_valid_out <= 1'b1;
            end else begin
                rx_overrun_out <= 1'b1;
            end
        end else if (cpu_rden_in && cpu_valid_out) begin
            cpu_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_uart_endpoint.sv
// Scoreboard bench for serial_uart_endpoint at CLKS_PER_BIT=4, TX_DEPTH=4.
module tb_serial_uart_endpoint;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] cpu_data_in;
    logic       cpu_wren_in;
    logic       cpu_rden_in;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out;
    logic       cpu_ready_out;
    logic       uart_rx_in;
    logic       uart_tx_out;
    logic       rx_overrun_out;

    int checks = 0;
    int passed = 0;
    int model_count = 0;
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];

    serial_uart_endpoint #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_data_in   (cpu_data_in),
        .cpu_wren_in   (cpu_wren_in),
        .cpu_rden_in   (cpu_rden_in),
        .cpu_data_out  (cpu_data_out),
        .cpu_valid_out (cpu_valid_out),
        .cpu_ready_out (cpu_ready_out),
        .uart_rx_in    (uart_rx_in),
        .uart_tx_out   (uart_tx_out),
        .rx_overrun_out(rx_overrun_out)
    );

    always #5 clock = ~clock;

    // Push at the next rising edge; the model accepts only when not full.
    task automatic push_byte(input logic [7:0] d);
        @(negedge clock);
        cpu_data_in = d;
        cpu_wren_in = 1'b1;
        @(posedge clock);
        if (model_count < DEPTH) begin
            tx_sb.push_back(d);
            model_count++;
        end
        #1 cpu_wren_in = 1'b0;
    endtask

    // Expects lead_high idle cycles, then every queued frame back-to-back, then idle.
    task automatic tx_monitor(input int lead_high);
        int bad;
        logic [7:0] b;
        logic [9:0] frame;
        bad = 0;
        repeat (lead_high) begin
            @(negedge clock);
            if (uart_tx_out !== 1'b1) bad++;
        end
        checks++;
        if (bad == 0) passed++;
        else $display("FAIL tx_lead_idle: %0d low cycles, required 0", bad);
        while (tx_sb.size() > 0) begin
            b = tx_sb.pop_front();
            model_count--;
            frame = {1'b1, b, 1'b0};
            bad = 0;
            for (int i = 0; i < 10 * CPB; i++) begin
                @(negedge clock);
                if (uart_tx_out !== frame[i / CPB]) bad++;
            end
            checks++;
            if (bad == 0) passed++;
            else $display("FAIL tx_frame_%02h: %0d wrong bit-cycles, required 0", b, bad);
        end
        @(negedge clock);
        checks++;
        if (uart_tx_out === 1'b1) passed++;
        else $display("FAIL tx_trailing_idle: line=%b required 1", uart_tx_out);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (uart_tx_out === 1'b1) passed++;
        else $display("FAIL reset_tx: got %b required 1", uart_tx_out);
        checks++;
        if (cpu_valid_out === 1'b0) passed++;
        else $display("FAIL reset_valid: got %b required 0", cpu_valid_out);
        checks++;
        if (cpu_data_out === 8'h00) passed++;
        else $display("FAIL reset_data: got %02h required 00", cpu_data_out);
        checks++;
        if (rx_overrun_out === 1'b0) passed++;
        else $display("FAIL reset_overrun: got %b required 0", rx_overrun_out);
        checks++;
        if (cpu_ready_out === 1'b1) passed++;
        else $display("FAIL reset_ready: got %b required 1", cpu_ready_out);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_tx_55();
        push_byte(8'h55);
        tx_monitor(2);
    endtask

    // Lead byte keeps the transmitter busy so the FIFO fills to DEPTH.
    task automatic test_back_to_back();
        push_byte(8'hA5);
        fork
            tx_monitor(2);
            begin
                repeat (3) @(negedge clock);
                for (int k = 1; k <= 5; k++) begin
                    push_byte(8'(k));
                    checks++;
                    if (cpu_ready_out === (model_count != DEPTH)) passed++;
                    else $display("FAIL ready_after_push_%0d: got %b required %b",
                                  k, cpu_ready_out, (model_count != DEPTH));
                end
            end
        join
        repeat (2) @(negedge clock);
    endtask

`ifndef SERIAL_LOOPBACK_EN
    task automatic send_rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            uart_rx_in = f[i];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        uart_rx_in = 1'b1;
    endtask

    task automatic test_rx_basic();
        logic got;
        logic [7:0] exp;
        rx_sb.push_back(8'hA3);
        send_rx_frame(8'hA3, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 12 * CPB && !got; i++) begin
            @(negedge clock);
            if (cpu_valid_out === 1'b1) got = 1'b1;
        end
        exp = rx_sb.pop_front();
        checks++;
        if (got) passed++;
        else $display("FAIL rx_a3_valid: valid never rose, required 1");
        checks++;
        if (cpu_data_out === exp) passed++;
        else $display("FAIL rx_a3_data: got %02h required %02h", cpu_data_out, exp);
        @(negedge clock);
        cpu_rden_in = 1'b1;
        @(posedge clock);
        #1 cpu_rden_in = 1'b0;
        @(negedge clock);
        checks++;
        if (cpu_valid_out === 1'b0) passed++;
        else $display("FAIL rx_rden_clear: valid=%b required 0", cpu_valid_out);
    endtask

    task automatic test_rx_overrun();
        logic got;
        logic [7:0] exp;
        rx_sb.push_back(8'h11);
        send_rx_frame(8'h11, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 12 * CPB && !got; i++) begin
            @(negedge clock);
            if (cpu_valid_out === 1'b1) got = 1'b1;
        end
        checks++;
        if (got) passed++;
        else $display("FAIL rx_11_valid: valid never rose, required 1");
        send_rx_frame(8'h22, 1'b1);
        repeat (10) @(negedge clock);
        exp = rx_sb.pop_front();
        checks++;
        if (cpu_data_out === exp) passed++;
        else $display("FAIL overrun_data: got %02h required %02h", cpu_data_out, exp);
        checks++;
        if (rx_overrun_out === 1'b1) passed++;
        else $display("FAIL overrun_flag: got %b required 1", rx_overrun_out);
        @(negedge clock);
        cpu_rden_in = 1'b1;
        @(posedge clock);
        #1 cpu_rden_in = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (rx_overrun_out === 1'b1 && cpu_valid_out === 1'b0) passed++;
        else $display("FAIL overrun_sticky: overrun=%b valid=%b required 1/0",
                      rx_overrun_out, cpu_valid_out);
    endtask

    task automatic test_rx_errors();
        logic got;
        logic [7:0] exp;
        send_rx_frame(8'hC3, 1'b0);
        repeat (8) @(negedge clock);
        checks++;
        if (cpu_valid_out === 1'b0) passed++;
        else $display("FAIL framing_discard: valid=%b required 0", cpu_valid_out);
        @(negedge clock);
        uart_rx_in = 1'b0;
        @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (12 * CPB) @(negedge clock);
        checks++;
        if (cpu_valid_out === 1'b0) passed++;
        else $display("FAIL glitch_reject: valid=%b required 0", cpu_valid_out);
        rx_sb.push_back(8'h5A);
        send_rx_frame(8'h5A, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 12 * CPB && !got; i++) begin
            @(negedge clock);
            if (cpu_valid_out === 1'b1) got = 1'b1;
        end
        exp = rx_sb.pop_front();
        checks++;
        if (got && cpu_data_out === exp) passed++;
        else $display("FAIL rx_after_errors: valid=%b data=%02h required 1/%02h",
                      got, cpu_data_out, exp);
        @(negedge clock);
        cpu_rden_in = 1'b1;
        @(posedge clock);
        #1 cpu_rden_in = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_tx();
        push_byte(8'h00);
        repeat (12) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        tx_sb.delete();
        rx_sb.delete();
        model_count = 0;
        checks++;
        if (uart_tx_out === 1'b1) passed++;
        else $display("FAIL reset_mid_tx_line: got %b required 1", uart_tx_out);
        @(negedge clock);
        checks++;
        if (cpu_ready_out === 1'b1 && rx_overrun_out === 1'b0) passed++;
        else $display("FAIL reset_mid_tx_state: ready=%b overrun=%b required 1/0",
                      cpu_ready_out, rx_overrun_out);
        reset = 1'b1;
        repeat (2) @(negedge clock);
`ifdef SERIAL_LOOPBACK_EN
        begin
            logic got;
            logic [7:0] exp;
            rx_sb.push_back(8'h3C);
            push_byte(8'h3C);
            tx_sb.delete();
            model_count = 0;
            got = 1'b0;
            for (int i = 0; i < 25 * CPB && !got; i++) begin
                @(negedge clock);
                if (cpu_valid_out === 1'b1) got = 1'b1;
            end
            exp = rx_sb.pop_front();
            checks++;
            if (got && cpu_data_out === exp) passed++;
            else $display("FAIL loopback_3c: valid=%b data=%02h required 1/%02h",
                          got, cpu_data_out, exp);
        end
`else
        push_byte(8'h3C);
        tx_monitor(2);
`endif
    endtask

    initial begin
        cpu_data_in = 8'h00;
        cpu_wren_in = 1'b0;
        cpu_rden_in = 1'b0;
        uart_rx_in  = 1'b1;
        reset       = 1'b0;
        test_reset();
        test_tx_55();
        test_back_to_back();
`ifndef SERIAL_LOOPBACK_EN
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
`endif
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_uart_endpoint.md
SERIAL_UART_ENDPOINT -- requirements
Module: serial_uart_endpoint

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL be the clock cycles per UART bit (legal range 4..65535).
REQ-002 Parameter TX_DEPTH, default 4, SHALL be the TX FIFO depth in bytes (power of two, 2..16).
REQ-003 clock  in  1  single rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 cpu_data_in  in  8  byte written by the processor serial MMIO port.
REQ-006 cpu_wren_in  in  1  one-cycle write strobe for cpu_data_in.
REQ-007 cpu_rden_in  in  1  one-cycle read strobe consuming cpu_data_out.
REQ-008 cpu_data_out  out  8  received byte presented to the processor.
REQ-009 cpu_valid_out  out  1  cpu_data_out holds an unread byte.
REQ-010 cpu_ready_out  out  1  TX FIFO can accept a byte.
REQ-011 uart_rx_in  in  1  asynchronous UART receive line (idle high).
REQ-012 uart_tx_out  out  1  UART transmit line, registered (idle high).
REQ-013 rx_overrun_out  out  1  sticky flag: a received byte was dropped.

Function
REQ-014 The UART frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, with each bit held exactly CLKS_PER_BIT cycles.
REQ-015 cpu_ready_out SHALL equal (FIFO count != TX_DEPTH) combinationally from registered count.
REQ-016 A push on cpu_wren_in SHALL occur only if the FIFO is not full before the edge; a write while full SHALL be dropped with no state change.
REQ-017 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order; read/write pointers SHALL wrap modulo TX_DEPTH.
REQ-018 The TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_STOP; TX_IDLE->TX_START pops the FIFO head into a shift register when the FIFO is non-empty.
REQ-019 With the FSM in TX_IDLE and the FIFO empty, a push at edge N SHALL drive uart_tx_out low from edge N+2.
REQ-020 After TX_STOP completes, the FSM SHALL start the next frame back-to-back (no idle bit) if the FIFO is non-empty, else return to TX_IDLE.
REQ-021 uart_rx_in SHALL pass through a two-flop synchronizer before any use.
REQ-022 The RX FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP; a falling edge in RX_IDLE enters RX_START.
REQ-023 RX_START SHALL resample at CLKS_PER_BIT/2; if the line is high it returns to RX_IDLE (glitch reject), otherwise it enters RX_DATA.
REQ-024 RX_DATA SHALL sample each of the 8 bits at mid-bit, one CLKS_PER_BIT apart.
REQ-025 RX_STOP SHALL sample the stop bit mid-bit; if it is 0 (framing error), the byte SHALL be discarded silently.
REQ-026 A good byte SHALL load cpu_data_out and set cpu_valid_out on the edge after the stop-bit sample.
REQ-027 cpu_rden_in with cpu_valid_out high SHALL clear cpu_valid_out on that edge; cpu_rden_in while not valid SHALL be ignored.
REQ-028 A good byte arriving while cpu_valid_out is high and there is no same-edge rden SHALL be dropped and SHALL set rx_overrun_out.
REQ-029 A same-edge rden and new good byte SHALL load the new byte and keep cpu_valid_out high.

Reset
REQ-030 While reset is low, the following SHALL hold on every edge: FIFO empty; both FSMs idle; uart_tx_out=1; cpu_data_out=0; cpu_valid_out=0; rx_overrun_out=0; cpu_ready_out=1 on the following cycle.
REQ-031 Reset asserted mid-frame SHALL abort the frame, drive the line high from the next edge, and discard partial RX data.
REQ-032 rx_overrun_out SHALL clear only by reset.

Configuration
REQ-033 With macro SERIAL_LOOPBACK_EN defined, the RX synchronizer input SHALL be uart_tx_out and uart_rx_in SHALL be ignored.
REQ-034 Without SERIAL_LOOPBACK_EN defined, the RX path SHALL use uart_rx_in and no loopback logic SHALL exist.

Structure
REQ-035 A shared package serial_uart_pkg SHALL hold the TX and RX state enums and the frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
REQ-036 The TX FIFO SHALL be a sub-module named serial_tx_fifo, parameterized by TX_DEPTH; the TX and RX FSMs SHALL stay in the top module.

Verification (CLKS_PER_BIT=4)
REQ-037 Push 0x55 while idle -> uart_tx_out low at N+2, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles.
REQ-038 Five pushes 0x01..0x05 back-to-back with TX_DEPTH=4 -> cpu_ready_out low after the 4th push; 0x05 dropped; 0x01..0x04 sent contiguously.
REQ-039 Drive an RX frame of 0xA3 -> cpu_valid_out=1 with cpu_data_out=0xA3; rden -> cpu_valid_out=0 next cycle.
REQ-040 Send 0x11 then 0x22 with no rden -> cpu_data_out stays 0x11 and rx_overrun_out=1.
REQ-041 RX frame with stop bit 0, then a 1-cycle low glitch -> cpu_valid_out stays 0 throughout.
REQ-042 Reset low mid-TX-frame with SERIAL_LOOPBACK_EN defined -> uart_tx_out=1 next edge, FIFO empty; a loopback push of 0x3C afterward is received as 0x3C.
